// File: rtl/spi_byte_master.sv
// spi_byte_master
//   SPI mode-0 (CPOL=0, CPHA=0) master. Sends one byte per chip-select frame,
//   MSB first, with programmable CS setup, CS hold and inter-frame gap.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   tx_data   byte to send
//   tx_valid  send request, sampled only while tx_ready is high
//   tx_ready  high only while idle
//   busy      high from acceptance until tx_ready reasserts
//   done      one-cycle pulse coincident with CS rising at end of frame
//   CS        active-low chip select, idles high
//   SCK       serial clock, idles low
//   MOSI      serial data, changes only on SCK falling edges or CS edges
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for tx_valid; CS high, SCK low, MOSI low
// SETUP | CS low, MOSI holds bit 7, waiting SETUP_CYC cycles
// LOW   | SCK low phase of current bit, HALF_PERIOD cycles
// HIGH  | SCK high phase of current bit, HALF_PERIOD cycles
// HOLD  | after last SCK fall, CS still low for HOLD_CYC cycles
// GAP   | CS high, waiting GAP_CYC cycles before accepting again

module spi_byte_master #(
  parameter int unsigned HALF_PERIOD = 10,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned HOLD_CYC    = 5,
  parameter int unsigned GAP_CYC     = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       CS,
  output logic       SCK,
  output logic       MOSI
);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

  // Phase counter is loaded with N-1 and the state advances when it hits 0,
  // so every phase lasts exactly N cycles (N >= 1).
  localparam logic [15:0] SETUP_LD = 16'(SETUP_CYC - 1);
  localparam logic [15:0] HALF_LD  = 16'(HALF_PERIOD - 1);
  localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] GAP_LD   = 16'(GAP_CYC - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      CS       <= 1'b1;
      SCK      <= 1'b0;
      MOSI     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            shreg    <= tx_data;
            CS       <= 1'b0;
            MOSI     <= tx_data[7];
            bit_idx  <= 3'd7;
            cnt      <= SETUP_LD;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            cnt   <= HALF_LD;
            state <= LOW;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        LOW: begin
          if (cnt == '0) begin
            SCK   <= 1'b1;
            cnt   <= HALF_LD;
            state <= HIGH;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            SCK <= 1'b0;
            if (bit_idx != 3'd0) begin
              // next bit goes out on the same edge SCK falls
              MOSI    <= shreg[bit_idx - 3'd1];
              bit_idx <= bit_idx - 3'd1;
              cnt     <= HALF_LD;
              state   <= LOW;
            end else begin
              cnt   <= HOLD_LD;
              state <= HOLD;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            CS    <= 1'b1;
            MOSI  <= 1'b0;
            done  <= 1'b1;
            cnt   <= GAP_LD;
            state <= GAP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// tb_spi_byte_master
//   Drives two masters (default timing, and all-ones timing) and watches
//   their SPI pins with a pin-level monitor that rebuilds each frame from
//   SCK rising edges. Expected bytes and timings come from the protocol
//   rules as plain arithmetic on the timing parameters.

module tb_spi_byte_master;

  localparam int HP0 = 10, SU0 = 2, HO0 = 5, GA0 = 20;
  localparam int HP1 = 1,  SU1 = 1, HO1 = 1, GA1 = 1;

  typedef struct {
    int         mon;
    int         nbits;
    logic [7:0] data;
    int         cs_low;
    int         fall;
    int         rise;
    int         first_rise;
    int         last_rise;
    logic       done_at_rise;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data [2];
  logic       tx_valid [2];
  logic       ready_w [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic       cs_w [2];
  logic       sck_w [2];
  logic       mosi_w [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spi_byte_master #(.HALF_PERIOD(HP0), .SETUP_CYC(SU0), .HOLD_CYC(HO0), .GAP_CYC(GA0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(ready_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .CS(cs_w[0]), .SCK(sck_w[0]), .MOSI(mosi_w[0]));

  spi_byte_master #(.HALF_PERIOD(HP1), .SETUP_CYC(SU1), .HOLD_CYC(HO1), .GAP_CYC(GA1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(ready_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .CS(cs_w[1]), .SCK(sck_w[1]), .MOSI(mosi_w[1]));

  // ---------------- pin monitor ----------------
  frame_t     fq[$];
  logic       prev_cs [2] = '{1'b1, 1'b1};
  logic       prev_sck [2] = '{1'b0, 1'b0};
  logic       prev_mosi [2] = '{1'b0, 1'b0};
  logic       prev_ready [2] = '{1'b1, 1'b1};
  logic       prev_done [2] = '{1'b0, 1'b0};
  int         nbits [2] = '{0, 0};
  logic [7:0] shv [2] = '{8'h00, 8'h00};
  int         cs_low [2] = '{0, 0};
  int         fall_cyc [2] = '{0, 0};
  int         first_rise [2] = '{0, 0};
  int         last_rise [2] = '{0, 0};
  int         ready_rise [2] = '{0, 0};
  int         n_falls [2] = '{0, 0};
  int         n_rises [2] = '{0, 0};
  int         n_done [2] = '{0, 0};
  int         viol = 0;

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (prev_cs[m] && !cs_w[m]) begin
        fall_cyc[m] = cyc;
        nbits[m] = 0;
        shv[m] = 8'h00;
        cs_low[m] = 0;
        n_falls[m]++;
      end
      if (!cs_w[m]) cs_low[m]++;
      if (!prev_sck[m] && sck_w[m]) begin
        shv[m] = {shv[m][6:0], mosi_w[m]};
        nbits[m]++;
        n_rises[m]++;
        if (nbits[m] == 1) first_rise[m] = cyc;
        last_rise[m] = cyc;
      end
      if (!prev_cs[m] && cs_w[m])
        fq.push_back('{m, nbits[m], shv[m], cs_low[m], fall_cyc[m], cyc,
                       first_rise[m], last_rise[m], done_w[m]});
      if (!prev_ready[m] && ready_w[m]) ready_rise[m] = cyc;
      if (done_w[m]) n_done[m]++;
      if (done_w[m] && prev_done[m]) viol++;
      if (cs_w[m] && sck_w[m]) viol++;
      if (cs_w[m] && mosi_w[m]) viol++;
      if (prev_sck[m] && sck_w[m] && (mosi_w[m] !== prev_mosi[m])) viol++;
      if (busy_w[m] !== !ready_w[m]) viol++;
      prev_cs[m] = cs_w[m];
      prev_sck[m] = sck_w[m];
      prev_mosi[m] = mosi_w[m];
      prev_ready[m] = ready_w[m];
      prev_done[m] = done_w[m];
    end
  end

  // ---------------- helpers (no comparisons inside except timeouts) ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input int m);
    int t;
    t = 0;
    while (!ready_w[m] && t < 2000) begin
      tick();
      t++;
    end
    if (!ready_w[m]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_ready[%0d]: tx_ready=0 after %0d cycles, required 1", m, t);
    end
  endtask

  task automatic send_byte(input int m, input logic [7:0] d);
    wait_ready(m);
    tx_data[m] = d;
    tx_valid[m] = 1'b1;
    tick();
    tx_valid[m] = 1'b0;
  endtask

  task automatic get_frame(input int m, output frame_t f, output bit ok);
    ok = 1'b0;
    f = '{m, 0, 8'h00, 0, 0, 0, 0, 0, 1'b0};
    for (int t = 0; t < 2000 && !ok; t++) begin
      for (int i = 0; i < fq.size(); i++) begin
        if (!ok && fq[i].mon == m) begin
          f = fq[i];
          fq.delete(i);
          ok = 1'b1;
        end
      end
      if (!ok) tick();
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL get_frame[%0d]: no CS frame seen within budget, required one", m);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (cs_w[m] !== 1'b1)    begin n_bad++; $display("FAIL reset_cs[%0d]: got %b want 1", m, cs_w[m]); end
      n_cmp++; if (sck_w[m] !== 1'b0)   begin n_bad++; $display("FAIL reset_sck[%0d]: got %b want 0", m, sck_w[m]); end
      n_cmp++; if (mosi_w[m] !== 1'b0)  begin n_bad++; $display("FAIL reset_mosi[%0d]: got %b want 0", m, mosi_w[m]); end
      n_cmp++; if (done_w[m] !== 1'b0)  begin n_bad++; $display("FAIL reset_done[%0d]: got %b want 0", m, done_w[m]); end
      n_cmp++; if (busy_w[m] !== 1'b0)  begin n_bad++; $display("FAIL reset_busy[%0d]: got %b want 0", m, busy_w[m]); end
      n_cmp++; if (ready_w[m] !== 1'b1) begin n_bad++; $display("FAIL reset_ready[%0d]: got %b want 1", m, ready_w[m]); end
    end
  endtask

  task automatic test_single();
    frame_t f;
    bit ok;
    int d0;
    d0 = n_done[0];
    send_byte(0, 8'h02);
    get_frame(0, f, ok);
    wait_ready(0);
    tick();
    if (ok) begin
      n_cmp++; if (f.nbits != 8) begin n_bad++; $display("FAIL single_nbits: got %0d want 8", f.nbits); end
      n_cmp++; if (f.data !== 8'h02) begin n_bad++; $display("FAIL single_data: got %h want 02", f.data); end
      n_cmp++; if (f.cs_low != SU0 + 16*HP0 + HO0) begin n_bad++; $display("FAIL single_cs_low: got %0d want %0d", f.cs_low, SU0 + 16*HP0 + HO0); end
      n_cmp++; if (f.first_rise - f.fall != SU0 + HP0) begin n_bad++; $display("FAIL single_first_rise: got %0d want %0d", f.first_rise - f.fall, SU0 + HP0); end
      n_cmp++; if (f.last_rise - f.first_rise != 14*HP0) begin n_bad++; $display("FAIL single_rise_span: got %0d want %0d", f.last_rise - f.first_rise, 14*HP0); end
      n_cmp++; if (f.done_at_rise !== 1'b1) begin n_bad++; $display("FAIL single_done_at_cs_rise: got %b want 1", f.done_at_rise); end
      n_cmp++; if (ready_rise[0] - f.fall != SU0 + 16*HP0 + HO0 + GA0) begin n_bad++; $display("FAIL single_ready_back: got %0d want %0d", ready_rise[0] - f.fall, SU0 + 16*HP0 + HO0 + GA0); end
    end
    n_cmp++; if (n_done[0] - d0 != 1) begin n_bad++; $display("FAIL single_done_count: got %0d want 1", n_done[0] - d0); end
  endtask

  task automatic test_back_to_back();
    frame_t f1, f2;
    bit ok1, ok2;
    int fl0, rr, t;
    fl0 = n_falls[0];
    wait_ready(0);
    tx_data[0] = 8'hA5;
    tx_valid[0] = 1'b1;
    tick();
    tx_data[0] = 8'h3C;
    get_frame(0, f1, ok1);
    t = 0;
    while (n_falls[0] < fl0 + 2 && t < 2000) begin
      tick();
      t++;
    end
    rr = ready_rise[0];
    tx_valid[0] = 1'b0;
    get_frame(0, f2, ok2);
    n_cmp++; if (n_falls[0] - fl0 != 2) begin n_bad++; $display("FAIL b2b_frames: got %0d want 2", n_falls[0] - fl0); end
    if (ok1 && ok2) begin
      n_cmp++; if (f1.data !== 8'hA5 || f1.nbits != 8) begin n_bad++; $display("FAIL b2b_first: got %h/%0d want a5/8", f1.data, f1.nbits); end
      n_cmp++; if (f2.data !== 8'h3C || f2.nbits != 8) begin n_bad++; $display("FAIL b2b_second: got %h/%0d want 3c/8", f2.data, f2.nbits); end
      n_cmp++; if (rr - f1.rise != GA0) begin n_bad++; $display("FAIL b2b_gap: got %0d want %0d", rr - f1.rise, GA0); end
      n_cmp++; if (f2.fall - rr != 1) begin n_bad++; $display("FAIL b2b_accept_on_ready: got %0d want 1", f2.fall - rr); end
    end
    wait_ready(0);
  endtask

  task automatic test_ignore_midframe();
    frame_t f;
    bit ok;
    int fl0;
    fl0 = n_falls[0];
    send_byte(0, 8'h81);
    repeat (40) tick();
    tx_data[0] = 8'hFF;
    tx_valid[0] = 1'b1;
    tick();
    tx_valid[0] = 1'b0;
    get_frame(0, f, ok);
    wait_ready(0);
    repeat (10) tick();
    if (ok) begin
      n_cmp++; if (f.data !== 8'h81 || f.nbits != 8) begin n_bad++; $display("FAIL ignore_data: got %h/%0d want 81/8", f.data, f.nbits); end
    end
    n_cmp++; if (n_falls[0] - fl0 != 1) begin n_bad++; $display("FAIL ignore_frames: got %0d want 1", n_falls[0] - fl0); end
  endtask

  task automatic test_reset_midframe();
    frame_t f;
    bit ok;
    int r0, d0, t;
    r0 = n_rises[0];
    d0 = n_done[0];
    send_byte(0, 8'hF0);
    t = 0;
    while (n_rises[0] < r0 + 3 && t < 2000) begin
      tick();
      t++;
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (cs_w[0] !== 1'b1 || sck_w[0] !== 1'b0 || mosi_w[0] !== 1'b0) begin
      n_bad++; $display("FAIL async_reset_pins: got cs=%b sck=%b mosi=%b want 1/0/0", cs_w[0], sck_w[0], mosi_w[0]);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    get_frame(0, f, ok);
    tick();
    if (ok) begin
      n_cmp++; if (f.nbits != 3) begin n_bad++; $display("FAIL reset_partial_bits: got %0d want 3", f.nbits); end
    end
    n_cmp++; if (n_done[0] != d0) begin n_bad++; $display("FAIL reset_no_done: got %0d pulses want 0", n_done[0] - d0); end
    send_byte(0, 8'h55);
    get_frame(0, f, ok);
    if (ok) begin
      n_cmp++; if (f.data !== 8'h55 || f.nbits != 8) begin n_bad++; $display("FAIL reset_recover: got %h/%0d want 55/8", f.data, f.nbits); end
    end
    wait_ready(0);
  endtask

  task automatic test_fast();
    frame_t f;
    bit ok;
    send_byte(1, 8'hC3);
    get_frame(1, f, ok);
    if (ok) begin
      n_cmp++; if (f.data !== 8'hC3 || f.nbits != 8) begin n_bad++; $display("FAIL fast_data: got %h/%0d want c3/8", f.data, f.nbits); end
      n_cmp++; if (f.cs_low != SU1 + 16*HP1 + HO1) begin n_bad++; $display("FAIL fast_cs_low: got %0d want %0d", f.cs_low, SU1 + 16*HP1 + HO1); end
      n_cmp++; if (f.last_rise - f.first_rise != 14*HP1) begin n_bad++; $display("FAIL fast_rise_span: got %0d want %0d", f.last_rise - f.first_rise, 14*HP1); end
    end
    wait_ready(1);
  endtask

  task automatic test_random();
    frame_t f;
    bit ok;
    int m, d_start [2], cnt [2];
    logic [7:0] d;
    d_start[0] = n_done[0];
    d_start[1] = n_done[1];
    cnt[0] = 0;
    cnt[1] = 0;
    for (int i = 0; i < 16; i++) begin
      m = (i % 3 == 2) ? 1 : 0;
      d = 8'($urandom);
      repeat ($urandom_range(0, 25)) tick();
      send_byte(m, d);
      get_frame(m, f, ok);
      cnt[m]++;
      if (ok) begin
        n_cmp++; if (f.data !== d || f.nbits != 8) begin n_bad++; $display("FAIL random_byte[%0d]: got %h/%0d want %h/8", i, f.data, f.nbits, d); end
      end
    end
    wait_ready(0);
    wait_ready(1);
    tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (n_done[k] - d_start[k] != cnt[k]) begin n_bad++; $display("FAIL random_done_count[%0d]: got %0d want %0d", k, n_done[k] - d_start[k], cnt[k]); end
    end
  endtask

  task automatic test_protocol();
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL protocol_monitor: got %0d violations want 0", viol); end
  endtask

  initial begin
    tx_data[0] = 8'h00;
    tx_data[1] = 8'h00;
    tx_valid[0] = 1'b0;
    tx_valid[1] = 1'b0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    repeat (2) tick();
    test_single();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
    test_fast();
    test_random();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
